imm_enc: RTL

Immediate encoder: the inverse of the core's immediate generator. Takes a 32-bit immediate value and an `imm_ctrl` format selector and produces the 25-bit instruction field INST[31:7] with the immediate bits placed in their RISC-V positions and all non-immediate bit positions zero. It range-checks the value against the format, flags illegal values, and carries each result through a 2-stage valid/ready pipeline. The debug/boot instruction-injection path uses it to build instruction words, and the decoder round-trip bench uses it as a reference model.

---
 rtl/imm_enc.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imm_enc.sv
// imm_enc: immediate encoder, inverse of the immediate generator.
// Two-stage valid/ready pipe producing INST[31:7] plus an error flag.

package control_types;
  typedef enum logic [2:0] {
    SE20_UI = 3'd0,
    SE12_LI = 3'd1,
    SE05    = 3'd2,
    SE12_BR = 3'd3,
    SE12_ST = 3'd5,
    SE20_JP = 3'd6
  } imm_ctrl;
endpackage

module imm_enc
  import control_types::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IMM,
  input  logic [2:0]  IMM_SEL,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [24:0] OUT,
  output logic        ERR,
  output logic [15:0] ENC_CNT,
  output logic [7:0]  ERR_CNT
);

  logic        s1_valid;
  logic [31:0] s1_imm;
  logic [2:0]  s1_sel;
  logic        s1_legal;
  logic        s2_valid;

  logic        s1_adv;
  logic        s2_adv;
  logic        in_legal;
  logic [24:0] enc;

  // Upper bits must replicate the format's sign bit.
  logic uni11;
  logic uni12;
  logic uni20;

  assign uni11 = (&IMM[31:11]) | ~(|IMM[31:11]);
  assign uni12 = (&IMM[31:12]) | ~(|IMM[31:12]);
  assign uni20 = (&IMM[31:20]) | ~(|IMM[31:20]);

  assign s2_adv    = !s2_valid || OUT_READY;
  assign s1_adv    = s1_valid && s2_adv;
  assign IN_READY  = !s1_valid || s2_adv;
  assign OUT_VALID = s2_valid;

  // Range/alignment check of the incoming value against its format.
  always_comb begin
    in_legal = 1'b0;
    case (IMM_SEL)
      SE20_UI: in_legal = ~(|IMM[11:0]);
      SE12_LI: in_legal = uni11;
      SE05:    in_legal = ~(|IMM[31:5]);
      SE12_BR: in_legal = ~IMM[0] & uni12;
      SE12_ST: in_legal = uni11;
      SE20_JP: in_legal = ~IMM[0] & uni20;
      default: in_legal = 1'b0;
    endcase
  end

  // Scatter the held immediate into its instruction-field positions.
  always_comb begin
    enc = '0;
    case (s1_sel)
      SE20_UI: enc[24:5] = s1_imm[31:12];
      SE12_LI: enc[24:13] = s1_imm[11:0];
      SE05:    enc[17:13] = s1_imm[4:0];
      SE12_BR: begin
        enc[24]    = s1_imm[12];
        enc[23:18] = s1_imm[10:5];
        enc[4:1]   = s1_imm[4:1];
        enc[0]     = s1_imm[11];
      end
      SE12_ST: begin
        enc[24:18] = s1_imm[11:5];
        enc[4:0]   = s1_imm[4:0];
      end
      SE20_JP: begin
        enc[24]    = s1_imm[20];
        enc[23:14] = s1_imm[10:1];
        enc[13]    = s1_imm[11];
        enc[12:5]  = s1_imm[19:12];
      end
      default: enc = '0;
    endcase
  end

  // Stage 1: capture the accepted beat and its legality.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_sel   <= '0;
      s1_legal <= 1'b0;
    end else if (IN_READY) begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_imm   <= IMM;
        s1_sel   <= IMM_SEL;
        s1_legal <= in_legal;
      end
    end
  end

  // Stage 2: packed result; illegal beats become OUT=0, ERR=1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid <= 1'b0;
      OUT      <= '0;
      ERR      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        OUT <= s1_legal ? enc : 25'd0;
        ERR <= !s1_legal;
      end
    end
  end

  // Delivered-beat counters; the error count saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ENC_CNT <= '0;
      ERR_CNT <= '0;
    end else if (s2_valid && OUT_READY) begin
      if (!ERR)
        ENC_CNT <= ENC_CNT + 16'd1;
      else if (ERR_CNT != 8'hFF)
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule
